// File: rtl/arb_pkg.sv
// Shared types and constants for the two-channel round-robin arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSE  = 2'd2
    } arb_state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Next FSM state from the current state, source occupancy, downstream
    // back-pressure and whether the read/capture pipeline is empty.
    function automatic arb_state_t next_state(
        input arb_state_t cur,
        input logic       any_data,
        input logic       afd,
        input logic       drained
    );
        arb_state_t nxt;
        nxt = cur;
        case (cur)
            IDLE: begin
                if (any_data) nxt = afd ? PAUSE : ACTIVE;
            end
            ACTIVE: begin
                if (afd)                       nxt = PAUSE;
                else if (!any_data && drained) nxt = IDLE;
            end
            PAUSE: begin
                if (!afd) nxt = any_data ? ACTIVE : IDLE;
            end
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rr_grant2.sv
// Eligibility check and round-robin pick between two source FIFOs,
// plus the register remembering which channel was granted last.
module rr_grant2
    import arb_pkg::*;
(
    input  logic clk8f,
    input  logic reset,
    input  logic empty0,
    input  logic empty1,
    input  logic read0,
    input  logic read1,
    input  logic enable,
    output logic grant0,
    output logic grant1
);

    logic last_grant;
    logic elig0;
    logic elig1;

    // A channel just popped is skipped for one cycle so its empty flag can settle.
    always_comb begin
        elig0  = !empty0 && !read0;
        elig1  = !empty1 && !read1;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (enable) begin
            if (elig0 && elig1) begin
                if (last_grant == CH0) grant1 = 1'b1;
                else                   grant0 = 1'b1;
            end else if (elig0) begin
                grant0 = 1'b1;
            end else if (elig1) begin
                grant1 = 1'b1;
            end
        end
    end

    // Remember the most recent winner; reset favours channel 0 first.
    always_ff @(posedge clk8f) begin
        if (reset) begin
            last_grant <= CH1;
        end else if (grant0) begin
            last_grant <= CH0;
        end else if (grant1) begin
            last_grant <= CH1;
        end
    end

endmodule

// File: rtl/arbitro_rr2.sv
// Two-channel round-robin arbiter draining two receive FIFOs into one
// downstream FIFO, tagging each byte with its source channel.
module arbitro_rr2
    import arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk8f,
    input  logic              reset,
    input  logic              empty0,
    input  logic              empty1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic              almost_full_dest,
    output logic              read0,
    output logic              read1,
    output logic [DATA_W-1:0] data_out,
    output logic              id_out,
    output logic              write_out,
    output logic              idle,
    output logic [CNT_W-1:0]  count0,
    output logic [CNT_W-1:0]  count1
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       grant0;
    logic       grant1;
    logic       rd_en;
    logic       b_valid;
    logic       b_id;

    // Reads are only launched while streaming and not back-pressured.
    always_comb begin
        rd_en     = (state == ACTIVE) && !almost_full_dest;
        state_nxt = next_state(state, !(empty0 && empty1), almost_full_dest,
                               !(read0 || read1 || b_valid));
    end

    rr_grant2 u_grant (
        .clk8f  (clk8f),
        .reset  (reset),
        .empty0 (empty0),
        .empty1 (empty1),
        .read0  (read0),
        .read1  (read1),
        .enable (rd_en),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    // FSM, read strobes, capture/write pipeline and per-channel counters.
    // Source data is valid the cycle after the pop, so stage B holds only
    // the channel tag and the byte is taken straight into data_out.
    always_ff @(posedge clk8f) begin
        if (reset) begin
            state     <= IDLE;
            read0     <= 1'b0;
            read1     <= 1'b0;
            b_valid   <= 1'b0;
            b_id      <= CH0;
            write_out <= 1'b0;
            data_out  <= '0;
            id_out    <= CH0;
            count0    <= '0;
            count1    <= '0;
            idle      <= 1'b1;
        end else begin
            state     <= state_nxt;
            read0     <= grant0;
            read1     <= grant1;
            b_valid   <= read0 || read1;
            b_id      <= read1 ? CH1 : CH0;
            write_out <= b_valid;
            if (b_valid) begin
                data_out <= (b_id == CH1) ? data1 : data0;
                id_out   <= b_id;
                if (b_id == CH1) count1 <= count1 + CNT_W'(1);
                else             count0 <= count0 + CNT_W'(1);
            end
            idle <= (state_nxt == IDLE) && !(read0 || read1) && !b_valid;
        end
    end

endmodule
